singleton_elim_scheduler: RTL and testbench
===========================================

// Module: singleton_elim_scheduler
// PURPOSE
//  Shares one singletonElimination pipeline (fixed latency, no stall input) between NUM_REQ graph producers.
//  Round-robin arbitration picks one 128-bit graph per cycle; each issued graph carries a requester tag.
//  The block aligns nonSingletons with singletonCount and buffers results in an output FIFO.
//  Credit-based issue guarantees the FIFO never overflows while out_ready is low.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  TAG_W       2   tag width, = $clog2(NUM_REQ)
//  NS_LAG      2   cycles from dp_graph_in to valid dp_non_singletons
//  CNT_LAG     7   cycles from dp_graph_in to valid dp_singleton_count (>= NS_LAG)
//  FIFO_DEPTH  8   output FIFO entries; >= CNT_LAG+1 needed for full throughput
// PORTS
//  clk                 in   1              clock
//  rst_n               in   1              synchronous reset, active low
//  req_valid           in   NUM_REQ        per-requester graph valid
//  req_graph           in   128*NUM_REQ    graph of requester i at [128*i +: 128]
//  req_ready           out  NUM_REQ        one-hot (or zero) accept, combinational
//  dp_graph_in         out  128            to datapath graphIn; 0 when no issue
//  dp_non_singletons   in   128            from datapath nonSingletons
//  dp_singleton_count  in   6              from datapath singletonCount
//  out_valid           out  1              result available
//  out_ready           in   1              consumer accepts result
//  out_graph           out  128            non-singleton graph
//  out_count           out  6              singleton count for that graph
//  out_tag             out  TAG_W          requester index of that graph
//  idle                out  1              no graph in flight and FIFO empty
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): RR pointer=0, valid/tag delay lines cleared, FIFO emptied, in_flight=0.
//   Outputs then: out_valid=0, req_ready=0 until next cycle's evaluation, idle=1, dp_graph_in=0.
//   Reset mid-operation discards all in-flight and buffered results; none appear at the output afterwards.
//  Credit: can_issue = (in_flight + fifo_count) < FIFO_DEPTH, computed from registered state only.
//  Arbiter: grant = first i with req_valid[i], searching ptr, ptr+1, ... wrapping mod NUM_REQ.
//   req_ready[grant]=can_issue; all other req_ready=0. Issue = req_valid[grant] & can_issue.
//   On issue: ptr <= grant+1 (mod NUM_REQ); otherwise ptr unchanged.
//   req_ready never depends on out_ready (no combinational path out_ready -> req_ready).
//  Issue path: dp_graph_in = req_graph[grant] on issue, else 128'b0 (combinational mux).
//   Valid+tag shift register of CNT_LAG stages; stage k is set k cycles after issue.
//  Alignment: dp_non_singletons sampled at NS_LAG, delayed CNT_LAG-NS_LAG registers; graph, count and tag
//   for one issue all present at stage CNT_LAG in the same cycle. If CNT_LAG==NS_LAG, no extra delay.
//  Push: valid at stage CNT_LAG pushes {tag, graph, count} into the FIFO. Credit rule guarantees not full.
//  FIFO: first-word-fall-through; out_* driven from head; pop on out_valid & out_ready.
//   Head data stable while out_valid & !out_ready. Push+pop same cycle at any occupancy: count unchanged.
//   Push into empty FIFO: out_valid rises the cycle after the push edge (total issue->out_valid = CNT_LAG+1).
//  in_flight: +1 on issue, -1 on push, unchanged when both; range 0..CNT_LAG.
//  Ordering: results leave in issue order (fixed latency + FIFO); tags identify the requester.
//  idle = (in_flight==0) & (fifo_count==0), registered-state based.
//  Widths: in_flight and fifo_count are $clog2(FIFO_DEPTH+1) bits; no wrap possible under the credit rule.
//  Pipeline input is zero on non-issue cycles so bubbles give nonSingletons=0, count=0 (ignored anyway).
// TESTING
//  1 Single req: req_valid=4'b0001, graph=128'h1 (lone vertex) -> out at cycle 8: graph=0, count=1, tag=0.
//  2 All 4 requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,... one issue/cycle, tags in order.
//  3 out_ready=0, continuous requests -> exactly FIFO_DEPTH issues then req_ready=0; no drop, no overflow;
//    raise out_ready -> 8 results in issue order, issue resumes once credit frees.
//  4 graph with vertices 0,1 and 3 (edge 0-1, 3 isolated) -> out_graph=128'h3, out_count=1.
//  5 rst_n=0 for 1 cycle while 5 graphs in flight + 3 buffered -> out_valid=0, idle=1, no stale outputs.
//  6 Req 2 only, then req 1 and 3 valid with ptr=3 -> grant 3 first, then 1 (wrap-around fairness).

Source files
------------

// File: rtl/singleton_elim_scheduler_if.sv
// Request/result handshake bundle for singleton_elim_scheduler.
// The slave modport is the scheduler; the master modport is the surrounding producers/consumer.
`timescale 1ns/1ps
interface singleton_elim_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [128*NUM_REQ-1:0] req_graph;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [127:0]           out_graph;
  logic [5:0]             out_count;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output req_valid, req_graph, out_ready,
    input  req_ready, out_valid, out_graph, out_count, out_tag
  );

  modport slave (
    input  req_valid, req_graph, out_ready,
    output req_ready, out_valid, out_graph, out_count, out_tag
  );
endinterface

// File: rtl/singleton_elim_scheduler.sv
// Round-robin sharing of one fixed-latency singletonElimination pipeline between NUM_REQ producers,
// with tag/result alignment and a credit-protected first-word-fall-through output FIFO.
`timescale 1ns/1ps
module singleton_elim_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = 2,
  parameter int NS_LAG     = 2,
  parameter int CNT_LAG    = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  singleton_elim_scheduler_if.slave sched,
  output logic [127:0]              dp_graph_in,
  input  logic [127:0]              dp_non_singletons,
  input  logic [5:0]                dp_singleton_count,
  output logic                      idle
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = TAG_W + 128 + 6;
  localparam logic [CW:0] DepthC = (CW + 1)'(FIFO_DEPTH);

  logic [TAG_W-1:0] rrPtr;
  logic [TAG_W-1:0] grant;
  logic             anyValid;
  logic             canIssue;
  logic             issue;
  int unsigned      idx;

  logic [CW-1:0]    inFlight;
  logic [CW-1:0]    fifoCount;

  logic [CNT_LAG-1:0] vldSr;
  logic [TAG_W-1:0]   tagSr [CNT_LAG];
  logic [127:0]       nsAligned;

  logic               push;
  logic               pop;
  logic [EW-1:0]      fifoMem [FIFO_DEPTH];
  logic [PW-1:0]      wrPtr;
  logic [PW-1:0]      rdPtr;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts everything issued but not yet popped, so a push can never find the FIFO full.
  assign canIssue = ({1'b0, inFlight} + {1'b0, fifoCount}) < DepthC;

  always_comb begin
    grant    = rrPtr;
    anyValid = 1'b0;
    idx      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(rrPtr) + off) % NUM_REQ;
      if (!anyValid && sched.req_valid[idx]) begin
        anyValid = 1'b1;
        grant    = TAG_W'(idx);
      end
    end
  end

  assign issue = anyValid & canIssue & rst_n;

  always_comb begin
    sched.req_ready = '0;
    if (issue) sched.req_ready[grant] = 1'b1;
  end

  assign dp_graph_in = issue ? sched.req_graph[128*32'(grant) +: 128] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rrPtr <= '0;
      vldSr <= '0;
      for (int unsigned k = 0; k < CNT_LAG; k++) tagSr[k] <= '0;
    end else begin
      if (issue) rrPtr <= (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + TAG_W'(1);
      vldSr[0] <= issue;
      tagSr[0] <= grant;
      for (int unsigned k = 1; k < CNT_LAG; k++) begin
        vldSr[k] <= vldSr[k-1];
        tagSr[k] <= tagSr[k-1];
      end
    end
  end

  // nonSingletons arrive early; hold them until the matching count is valid.
  generate
    if (CNT_LAG == NS_LAG) begin : gNoAlign
      assign nsAligned = dp_non_singletons;
    end else begin : gAlign
      logic [127:0] nsSr [CNT_LAG-NS_LAG];
      always_ff @(posedge clk) begin
        nsSr[0] <= dp_non_singletons;
        for (int unsigned j = 1; j < CNT_LAG - NS_LAG; j++) nsSr[j] <= nsSr[j-1];
      end
      assign nsAligned = nsSr[CNT_LAG-NS_LAG-1];
    end
  endgenerate

  assign push            = vldSr[CNT_LAG-1];
  assign sched.out_valid = (fifoCount != '0);
  assign pop             = sched.out_valid & sched.out_ready;
  assign {sched.out_tag, sched.out_graph, sched.out_count} = fifoMem[rdPtr];

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= {tagSr[CNT_LAG-1], nsAligned, dp_singleton_count};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      inFlight  <= '0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + CW'(1);
        2'b01:   fifoCount <= fifoCount - CW'(1);
        default: fifoCount <= fifoCount;
      endcase
      case ({issue, push})
        2'b10:   inFlight <= inFlight + CW'(1);
        2'b01:   inFlight <= inFlight - CW'(1);
        default: inFlight <= inFlight;
      endcase
    end
  end

  assign idle = (inFlight == '0) && (fifoCount == '0);
endmodule

// File: tb/tb_singleton_elim_scheduler.sv
// Self-checking bench for singleton_elim_scheduler: behavioural datapath, arbiter/credit model and scoreboard.
// Graph encoding used by the datapath model: [15:0] vertex mask, [127:16] fourteen {b,a} nibble-pair edges (a!=b).
`timescale 1ns/1ps
module tb_singleton_elim_scheduler;
  localparam int NUM_REQ    = 4;
  localparam int TAG_W      = 2;
  localparam int NS_LAG     = 2;
  localparam int CNT_LAG    = 7;
  localparam int FIFO_DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  singleton_elim_scheduler_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) sched ();

  logic [127:0] dpGraphIn;
  logic [127:0] dpNonSingletons;
  logic [5:0]   dpSingletonCount;
  logic         idle;

  singleton_elim_scheduler #(
    .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .NS_LAG(NS_LAG), .CNT_LAG(CNT_LAG), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sched(sched),
    .dp_graph_in(dpGraphIn),
    .dp_non_singletons(dpNonSingletons),
    .dp_singleton_count(dpSingletonCount),
    .idle(idle)
  );

  function automatic logic [15:0] nsMask(input logic [127:0] g);
    logic [15:0] m;
    logic [3:0]  a;
    logic [3:0]  b;
    m = '0;
    for (int e = 0; e < 14; e++) begin
      a = g[16+8*e +: 4];
      b = g[20+8*e +: 4];
      if (a != b && g[a] && g[b]) begin
        m[a] = 1'b1;
        m[b] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [127:0] nsOf(input logic [127:0] g);
    return {112'b0, nsMask(g)};
  endfunction

  function automatic logic [5:0] cntOf(input logic [127:0] g);
    logic [15:0] vm;
    vm = g[15:0];
    return 6'($countones(vm) - $countones(nsMask(g)));
  endfunction

  // Fixed-latency datapath: nonSingletons after NS_LAG, count after CNT_LAG.
  logic [127:0] dpPipe [1:CNT_LAG];
  always @(posedge clk) begin
    dpPipe[1] <= dpGraphIn;
    for (int k = 2; k <= CNT_LAG; k++) dpPipe[k] <= dpPipe[k-1];
  end
  assign dpNonSingletons  = nsOf(dpPipe[NS_LAG]);
  assign dpSingletonCount = cntOf(dpPipe[CNT_LAG]);

  logic [NUM_REQ-1:0] reqValid;
  logic [NUM_REQ-1:0] refill;
  logic [127:0]       reqGraph [NUM_REQ];
  logic               outReady;

  assign sched.req_valid = reqValid;
  assign sched.out_ready = outReady;
  always_comb begin
    sched.req_graph = '0;
    for (int i = 0; i < NUM_REQ; i++) sched.req_graph[128*i +: 128] = reqGraph[i];
  end

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [127:0]     graph;
    logic [5:0]       cnt;
    logic [31:0]      readyCyc;
  } exp_t;

  exp_t        sbq[$];
  int          mPtr = 0;
  int          outstanding = 0;
  int unsigned cyc = 0;
  int          acceptCount = 0;
  int          nChecks = 0;
  int          nPass = 0;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [127:0] randGraph();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle: compare at the falling edge, then cross the rising edge and advance the model.
  task automatic step();
    int g;
    bit found;
    bit expIssue;
    bit expOv;
    logic [NUM_REQ-1:0] expReady;
    exp_t e;
    #4;
    found = 0;
    g = mPtr;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && reqValid[(mPtr + off) % NUM_REQ]) begin
        found = 1;
        g = (mPtr + off) % NUM_REQ;
      end
    end
    expIssue = found && (outstanding < FIFO_DEPTH) && rst_n;
    expReady = '0;
    if (expIssue) expReady[g] = 1'b1;
    checkVal("req_ready", 128'(sched.req_ready), 128'(expReady));
    if ((sched.req_ready & sched.req_valid) != '0) acceptCount++;
    checkVal("dp_graph_in", dpGraphIn, expIssue ? reqGraph[g] : 128'b0);
    checkVal("idle", 128'(idle), 128'(outstanding == 0));
    expOv = (sbq.size() > 0) && (cyc >= sbq[0].readyCyc);
    checkVal("out_valid", 128'(sched.out_valid), 128'(expOv));
    if (expOv && outReady) begin
      e = sbq.pop_front();
      checkVal("out_tag", 128'(sched.out_tag), 128'(e.tag));
      checkVal("out_graph", sched.out_graph, e.graph);
      checkVal("out_count", 128'(sched.out_count), 128'(e.cnt));
      outstanding--;
    end
    if (expIssue) begin
      sbq.push_back('{tag: TAG_W'(g), graph: nsOf(reqGraph[g]), cnt: cntOf(reqGraph[g]),
                      readyCyc: cyc + CNT_LAG + 1});
      outstanding++;
      mPtr = (g + 1) % NUM_REQ;
    end
    @(posedge clk);
    #1;
    if (expIssue) begin
      if (refill[g]) reqGraph[g] = randGraph();
      else reqValid[g] = 1'b0;
    end
    if (!rst_n) begin
      sbq.delete();
      outstanding = 0;
      mPtr = 0;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reqValid = '0;
    refill   = '0;
    outReady = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) reqGraph[i] = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;

    // Lone vertex from requester 0.
    reqGraph[0] = 128'h1;
    reqValid    = 4'b0001;
    run(12);

    // Edge 0-1 plus isolated vertex 3, from requester 1.
    reqGraph[1] = 128'h10000B;
    reqValid    = 4'b0010;
    run(12);

    // Wrap-around fairness: requester 2 leaves the pointer at 3, then 1 and 3 compete.
    reqGraph[2] = randGraph();
    reqValid    = 4'b0100;
    run(2);
    reqGraph[1] = randGraph();
    reqGraph[3] = randGraph();
    reqValid    = 4'b1010;
    run(12);

    // Full-rate round robin with a free-flowing consumer.
    for (int i = 0; i < NUM_REQ; i++) reqGraph[i] = randGraph();
    refill   = '1;
    reqValid = '1;
    run(40);
    refill   = '0;
    reqValid = '0;
    run(12);

    // Stalled consumer: only FIFO_DEPTH issues may be accepted.
    outReady    = 1'b0;
    refill      = '1;
    reqValid    = '1;
    acceptCount = 0;
    run(20);
    checkVal("stall_issues", 128'(acceptCount), 128'(FIFO_DEPTH));
    outReady = 1'b1;
    run(30);
    refill   = '0;
    reqValid = '0;
    run(12);

    // Reset with 5 in flight and 3 buffered.
    outReady = 1'b0;
    refill   = '1;
    reqValid = '1;
    run(10);
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    refill   = '0;
    reqValid = '0;
    outReady = 1'b1;
    run(15);

    // Random back-pressure with continuous requests.
    refill   = '1;
    reqValid = '1;
    for (int i = 0; i < 60; i++) begin
      outReady = 1'($urandom_range(0, 1));
      step();
    end
    refill   = '0;
    reqValid = '0;
    outReady = 1'b1;
    for (int i = 0; i < 40 && sbq.size() > 0; i++) step();
    checkVal("drain", 128'(sbq.size()), 128'(0));
    run(2);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
